// File: rtl/display_multiplexado_pkg.sv
// Shared types and constants for the multiplexed hex display driver.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low segments, bit order g..a, indexed by nibble value 0..F.
    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/display_multiplexado_if.sv
// Load handshake, live controls and display pins between the cache logic and the driver.
interface display_multiplexado_if #(
    parameter int NUM_DIGITOS = 4
) ();
    import display_pkg::*;

    logic                       carrega;
    logic [4*NUM_DIGITOS-1:0]   dado;
    logic                       apaga_zeros;
    logic [NUM_DIGITOS-1:0]     piscar;
    logic                       pronto;
    seg_t                       saida;
    logic [NUM_DIGITOS-1:0]     anodo;

    modport master (
        output carrega, dado, apaga_zeros, piscar,
        input  pronto, saida, anodo
    );

    modport slave (
        input  carrega, dado, apaga_zeros, piscar,
        output pronto, saida, anodo
    );
endinterface

// File: rtl/display_multiplexado_decodificador_hex.sv
// Combinational hex nibble to active-low 7-segment decoder.
module decodificador_hex
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);
    assign o_seg = SEG_TABLE[i_nibble];
endmodule

// File: rtl/display_multiplexado.sv
// N-digit multiplexed hex display with frame-aligned loads, zero blanking and blink.
module display_multiplexado
    import display_pkg::*;
#(
    parameter int NUM_DIGITOS = 4,
    parameter int PRESCALE    = 50000,
    parameter int BLINK_DIV   = 256
) (
    input  logic                 clock,
    input  logic                 reset_n,
    display_multiplexado_if.slave bus
);
    localparam int IDX_W = clog2_min1(NUM_DIGITOS);
    localparam int PRE_W = clog2_min1(PRESCALE);
    localparam int BLK_W = clog2_min1(BLINK_DIV);
    localparam int DW    = 4 * NUM_DIGITOS;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITOS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0]       r_pre;
    logic [IDX_W-1:0]       r_idx;
    logic [BLK_W-1:0]       r_frame;
    logic                   r_fase;
    logic                   r_pronto;
    logic [DW-1:0]          r_pendente;
    logic [DW-1:0]          r_exibido;
    seg_t                   r_saida;
    logic [NUM_DIGITOS-1:0] r_anodo;

    logic                   w_tick;
    logic                   w_fim_quadro;
    logic [3:0]             w_nibble;
    seg_t                   w_seg;
    logic [NUM_DIGITOS-1:0] w_lead;
    logic [NUM_DIGITOS-1:0] w_sel;
    logic                   w_blank_zero;
    logic                   w_blink;

    assign w_tick       = (r_pre == PRE_LAST);
    assign w_fim_quadro = w_tick && (r_idx == IDX_LAST);

    // w_lead[k]: every nibble from k up to the most significant is zero.
    for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_dig
        assign w_lead[gi] = (r_exibido[DW-1:4*gi] == '0);
        assign w_sel[gi]  = (r_idx == IDX_W'(gi));
    end

    assign w_nibble     = r_exibido[{r_idx, 2'b00} +: 4];
    assign w_blank_zero = bus.apaga_zeros && w_lead[r_idx] && (r_idx != '0);
    assign w_blink      = r_fase && bus.piscar[r_idx];

    decodificador_hex u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_fase  <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            if (w_fim_quadro) begin
                if (r_frame == BLK_LAST) begin
                    r_frame <= '0;
                    r_fase  <= ~r_fase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    // A capture takes priority; the commit only happens while a value is pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pronto   <= 1'b1;
            r_pendente <= '0;
            r_exibido  <= '0;
        end else if (bus.carrega && r_pronto) begin
            r_pendente <= bus.dado;
            r_pronto   <= 1'b0;
        end else if (w_fim_quadro && !r_pronto) begin
            r_exibido <= r_pendente;
            r_pronto  <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_saida <= SEG_BLANK;
            r_anodo <= '1;
        end else begin
            r_saida <= (w_blink || w_blank_zero) ? SEG_BLANK : w_seg;
            r_anodo <= w_blink ? '1 : ~w_sel;
        end
    end

    assign bus.pronto = r_pronto;
    assign bus.saida  = r_saida;
    assign bus.anodo  = r_anodo;
endmodule

// File: tb/tb_display_multiplexado.sv
// Directed bench for display_multiplexado with 4 digits, PRESCALE=4, BLINK_DIV=2.
module tb_display_multiplexado;

    localparam logic [6:0] BLK = 7'b1111111;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    display_multiplexado_if #(.NUM_DIGITOS(4)) bus ();

    display_multiplexado #(
        .NUM_DIGITOS (4),
        .PRESCALE    (4),
        .BLINK_DIV   (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] v);
        bus.carrega = 1'b1;
        bus.dado    = v;
        @(negedge clock);
        bus.carrega = 1'b0;
        $display("load dado=%h az=%0b", v, bus.apaga_zeros);
        check("pronto_drop", 32'(bus.pronto), 32'd0);
    endtask

    task automatic wait_commit(input string tag);
        for (int i = 0; i < 100 && !bus.pronto; i++) @(negedge clock);
        check({tag, "_commit"}, 32'(bus.pronto), 32'd1);
    endtask

    // Called at the negedge right after the commit edge; slot s shows 1+4s edges later.
    task automatic check_frame(input string tag, input logic [27:0] exp_seg);
        logic [3:0] a;
        @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (4) @(negedge clock);
            a = 4'b1111;
            a[s] = 1'b0;
            check($sformatf("%s_seg%0d", tag, s), 32'(bus.saida), 32'(exp_seg[7*s +: 7]));
            check($sformatf("%s_an%0d", tag, s), 32'(bus.anodo), 32'(a));
        end
        $display("frame %s checked", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int target;
        logic [3:0] a;
        logic blank0;

        errors = 0;
        checks = 0;
        reset_n         = 1'b0;
        bus.carrega     = 1'b0;
        bus.dado        = '0;
        bus.apaga_zeros = 1'b0;
        bus.piscar      = '0;

        // Reset state, during reset and just after release
        repeat (3) @(negedge clock);
        check("rst_saida", 32'(bus.saida), 32'(BLK));
        check("rst_anodo", 32'(bus.anodo), 32'hF);
        check("rst_pronto", 32'(bus.pronto), 32'd1);
        reset_n = 1'b1;
        #1;
        check("rel_saida", 32'(bus.saida), 32'(BLK));
        check("rel_anodo", 32'(bus.anodo), 32'hF);

        // Basic load and decode
        load(16'h12AF);
        wait_commit("12AF");
        check_frame("12AF", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

        // Leading-zero blanking
        bus.apaga_zeros = 1'b1;
        load(16'h0050);
        wait_commit("0050");
        check_frame("0050", {BLK, BLK, 7'b0010010, 7'b1000000});

        load(16'h0000);
        wait_commit("0000");
        check_frame("0000", {BLK, BLK, BLK, 7'b1000000});

        // Load while busy is ignored
        bus.apaga_zeros = 1'b0;
        load(16'h3456);
        bus.carrega = 1'b1;
        bus.dado    = 16'h789A;
        @(negedge clock);
        bus.carrega = 1'b0;
        $display("load dado=789A while busy");
        wait_commit("3456");
        check_frame("3456", {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});
        check("single_commit_a", 32'(bus.pronto), 32'd1);
        repeat (20) @(negedge clock);
        check("single_commit_b", 32'(bus.pronto), 32'd1);

        // Asynchronous reset with a load pending, then blink on digit 0
        load(16'hBEEF);
        repeat (3) @(negedge clock);
        #2;
        reset_n    = 1'b0;
        bus.piscar = 4'b0001;
        #1;
        check("arst_saida", 32'(bus.saida), 32'(BLK));
        check("arst_anodo", 32'(bus.anodo), 32'hF);
        check("arst_pronto", 32'(bus.pronto), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 4; s++) begin
                target = 16 * f + 4 * s + 2;
                repeat (target - cyc) @(posedge clock);
                cyc = target;
                #1;
                blank0 = (s == 0) && ((f % 4) >= 2);
                a = 4'b1111;
                if (!blank0) a[s] = 1'b0;
                check($sformatf("blink_f%0d_seg%0d", f, s), 32'(bus.saida),
                      blank0 ? 32'(BLK) : 32'h40);
                check($sformatf("blink_f%0d_an%0d", f, s), 32'(bus.anodo), 32'(a));
            end
            $display("blink frame %0d checked", f);
        end
        check("discard_pronto", 32'(bus.pronto), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_multiplexado.md
Name: display_multiplexado

Overview:
- Parametrised N-digit hexadecimal 7-segment display driver. Successor to the single 3-bit digit decoder.
- Decodes 0-F per digit and time-multiplexes the digits over one shared segment bus plus per-digit anode enables.
- Adds leading-zero blanking and a per-digit blink mask.
- Updates from the cache datapath arrive through a load/ready handshake and are committed only at frame boundaries, so a value never tears across a scan frame.
- Sits between the cache debug/status logic and the board display pins.

Parameters:
- NUM_DIGITOS, 4: number of multiplexed digits (>=1).
- PRESCALE, 50000: clock cycles per scan tick, i.e. per digit slot (>=1).
- BLINK_DIV, 256: scan frames per blink half-period (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- carrega  in  1  load strobe; accepted only when pronto=1.
- dado  in  4*NUM_DIGITOS  hex nibbles; nibble k = dado[4k+3:4k]; digit 0 is least significant.
- apaga_zeros  in  1  leading-zero blanking enable (level, sampled live).
- piscar  in  NUM_DIGITOS  per-digit blink mask (level, sampled live).
- pronto  out  1  ready: 1 when no load is pending.
- saida  out  7  segments, active-low; saida[0]=a ... saida[6]=g.
- anodo  out  NUM_DIGITOS  digit enables, active-low, at most one low at a time.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: prescaler=0, idx=0, exibido=0, pendente=0, pronto=1, fase=0, frame counter=0, saida=7'b1111111, anodo=all ones.
- Prescaler: counts 0..PRESCALE-1.
  - tick=1 in the cycle where the count equals PRESCALE-1; the count then wraps to 0.
  - With PRESCALE=1, tick=1 every cycle.
- Scan: on each tick, idx increments and wraps from NUM_DIGITOS-1 to 0.
  - fim_quadro = tick && idx==NUM_DIGITOS-1.
- Outputs are registered: saida/anodo reflect idx one cycle after idx changes. anodo[idx]=0, all other anodo bits=1.
- Hex decode of nibble v (active-low, g..a):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
  - Blank = 1111111.
- Leading-zero blanking: with apaga_zeros=1, digit k is blanked iff exibido nibbles k..NUM_DIGITOS-1 are all 0 and k>0. Digit 0 is never blanked (value 0 shows "0").
- Blink:
  - The frame counter counts fim_quadro events 0..BLINK_DIV-1; at the wrap, fase toggles.
  - When fase=1 and piscar[idx]=1, the current slot is blanked: saida=1111111 and anodo stays all ones for that slot.
- Blanked slot from zero-blanking: saida=1111111, anodo[idx] still driven low.
- Load handshake:
  - If carrega=1 and pronto=1: pendente<=dado and pronto<=0 on the next edge.
  - If carrega=1 and pronto=0: ignored, with no effect on pendente.
  - On fim_quadro while pronto=0: exibido<=pendente and pronto<=1 on the same edge. The new value is first visible in digit slot 0 of the next frame.
  - Simultaneous carrega (pronto=1) and fim_quadro: capture only; commit happens at the following fim_quadro.
- Reset asserted mid-frame or mid-load: every register is cleared immediately, asynchronously. Any pending value is discarded. After release, scanning restarts at idx=0.
- Widths: idx width is clog2(NUM_DIGITOS), minimum 1. Prescaler width is clog2(PRESCALE), minimum 1. No arithmetic overflow is permitted outside the defined wraps.

Decomposition:
- Package display_pkg holds:
  - SEG_BLANK=7'b1111111;
  - a 16-entry segment lookup constant (the table above);
  - a typedef for the 7-bit segment vector.
- One sub-module: decodificador_hex.
  - Combinational, 4-bit in, 7-bit active-low out, driven from the package table.
  - Instantiated once, fed by the mux of exibido[idx].

Test Plan:
- Reset, NUM_DIGITOS=4, PRESCALE=4: saida=1111111, anodo=1111 during reset and on the first cycle after release; pronto=1.
- Load dado=16'h12AF: pronto drops the next cycle and returns at the first fim_quadro. In the next frame, slots 0..3 show F=0001110/anodo=1110, A=0001000/1101, 2=0100100/1011, 1=1111001/0111.
- dado=16'h0050 with apaga_zeros=1: digits 3 and 2 give saida=1111111, digit 1 gives 0010010, digit 0 gives 1000000. dado=16'h0000 leaves only digit 0 lit showing "0".
- Second carrega while pronto=0 with a different value: ignored; the display shows the first value after commit, and pronto=1 after exactly one commit.
- BLINK_DIV=2, piscar=4'b0001: digit 0 has anodo=1111 for 2 frames, visible for 2 frames, repeating; the other digits are unaffected.
- Assert reset_n=0 mid-frame with a load pending: outputs are immediately blank and pronto=1. After release, the old exibido=0 shows as "0000" (apaga_zeros=0).
